uart_rx_multi: RTL and testbench

Parametrised next-generation UART receiver for the CoreUARTapb fabric. Oversamples `rx` on `baud_clock` enables, glitch-filters it, and deframes 5–8 data bits with optional parity and 1 or 2 stop bits. It flags framing, parity, overflow and break conditions. Received words, each tagged with its error flags, go into a holding buffer that the APB register block reads through a valid/read handshake.

---
 rtl/uart_rx_multi_if.sv | 23 ++
 rtl/uart_rx_multi.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_multi_if.sv
// Receive-buffer read port of uart_rx_multi.
//   rx_read     : pop the head entry (ignored when the buffer is empty)
//   rx_data     : head data, LSB-aligned, unused MSBs zero
//   rx_valid    : buffer not empty
//   parity_err  : parity-error tag of the head entry
//   framing_err : framing-error tag of the head entry
// master = receiver side, slave = register block side.
interface uart_rx_multi_if;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;

    modport master (
        input  rx_read,
        output rx_data, rx_valid, parity_err, framing_err
    );
    modport slave (
        output rx_read,
        input  rx_data, rx_valid, parity_err, framing_err
    );
endinterface

// File: rtl/uart_rx_multi.sv
// Oversampling UART receiver: 3-sample majority glitch filter, 5..8 data bits, optional
// parity, 1 or 2 stop bits, framing/parity/overflow/break detection, tagged receive buffer.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   baud_clock            : one-clk enable at OVERSAMPLE x baud rate
//   rx                    : serial line, idle high
//   data_bits, parity_en, odd_n_even, two_stop : frame format
//   clear_overflow, clear_break : clear the sticky flags
//   rd                    : buffer read port (see uart_rx_multi_if)
//   overflow, break_det   : sticky error flags
//   rx_idle               : receiver state machine is idle
// Build option: define UART_RX_MULTI_FIFO_EN for a FIFO_DEPTH-entry circular buffer;
// otherwise a single holding register is used.
module uart_rx_multi #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   baud_clock,
    input  logic                   rx,
    input  logic [1:0]             data_bits,
    input  logic                   parity_en,
    input  logic                   odd_n_even,
    input  logic                   two_stop,
    input  logic                   clear_overflow,
    input  logic                   clear_break,
    uart_rx_multi_if.master        rd,
    output logic                   overflow,
    output logic                   break_det,
    output logic                   rx_idle
);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop1, StStop2, StBrkWait
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       samples_q;
    logic [TickW-1:0] tick_q, tick_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             acc_q, acc_d;     // running XOR of data bits
    logic             nz_q, nz_d;       // any 1 seen in data/parity (break qualifier)
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             overflow_q, break_q;

    logic             rx_f, centre, last_bit;
    logic             commit, commit_ferr, brk_set;
    logic [9:0]       word;

    assign rx_f = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                  (samples_q[1] & samples_q[2]);
    assign centre   = baud_clock && (tick_q == TickLast);
    assign last_bit = bit_q == ({2'b00, data_bits} + 4'd4);
    assign word     = {commit_ferr, perr_q, data_q};

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        data_d      = data_q;
        acc_d       = acc_q;
        nz_d        = nz_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        commit      = 1'b0;
        commit_ferr = ferr_q;
        brk_set     = 1'b0;
        if (baud_clock) begin
            tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (baud_clock && !rx_f) begin
                    tick_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_clock && (tick_q == TickHalf)) begin
                    if (!rx_f) begin
                        state_d = StData;
                        tick_d  = '0;
                        bit_d   = '0;
                        data_d  = '0;
                        acc_d   = 1'b0;
                        nz_d    = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (centre) begin
                    data_d[bit_q[2:0]] = rx_f;
                    acc_d = acc_q ^ rx_f;
                    nz_d  = nz_q | rx_f;
                    bit_d = bit_q + 4'd1;
                    if (last_bit) begin
                        state_d = parity_en ? StParity : StStop1;
                    end
                end
            end
            StParity: begin
                if (centre) begin
                    perr_d  = acc_q ^ rx_f ^ odd_n_even;
                    nz_d    = nz_q | rx_f;
                    state_d = StStop1;
                end
            end
            StStop1: begin
                if (centre) begin
                    ferr_d = ~rx_f;
                    if (!nz_q && !rx_f) begin
                        brk_set = 1'b1;
                        state_d = StBrkWait;
                    end else if (two_stop) begin
                        state_d = StStop2;
                    end else begin
                        // Return at the stop-bit centre for half a bit of resync margin.
                        commit      = 1'b1;
                        commit_ferr = ~rx_f;
                        state_d     = StIdle;
                    end
                end
            end
            StStop2: begin
                if (centre) begin
                    commit      = 1'b1;
                    commit_ferr = ferr_q | ~rx_f;
                    ferr_d      = commit_ferr;
                    state_d     = StIdle;
                end
            end
            StBrkWait: begin
                if (baud_clock && rx_f) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            samples_q <= 3'b111;
            tick_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            acc_q     <= 1'b0;
            nz_q      <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (baud_clock) begin
                samples_q <= {rx, samples_q[2:1]};
            end
            tick_q <= tick_d;
            bit_q  <= bit_d;
            data_q <= data_d;
            acc_q  <= acc_d;
            nz_q   <= nz_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
        end
    end

    // Receive buffer
    logic       valid, full, pop, ovf_set;
    logic [9:0] head;

`ifdef UART_RX_MULTI_FIFO_EN
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             push;

    assign valid = count_q != '0;
    assign full  = count_q == (AddrW + 1)'(FIFO_DEPTH);
    assign pop   = rd.rx_read && valid;
    // A same-cycle pop frees the slot before the write.
    assign push  = commit && (!full || pop);
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end
`else
    logic [9:0] hold_q;
    logic       full_q;
    logic       write;

    assign valid = full_q;
    assign full  = full_q;
    assign pop   = rd.rx_read && full_q;
    assign write = commit && (!full_q || pop);
    assign head  = hold_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (write) begin
                hold_q <= word;
                full_q <= 1'b1;
            end else if (pop) begin
                full_q <= 1'b0;
            end
        end
    end
`endif

    assign ovf_set = commit && full && !pop;

    // Sticky flags: a set event wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            overflow_q <= ovf_set | (overflow_q & ~clear_overflow);
            break_q    <= brk_set | (break_q & ~clear_break);
        end
    end

    assign rd.rx_valid    = valid;
    assign rd.rx_data     = valid ? head[7:0] : 8'h00;
    assign rd.parity_err  = valid & head[8];
    assign rd.framing_err = valid & head[9];
    assign overflow       = overflow_q;
    assign break_det      = break_q;
    assign rx_idle        = state_q == StIdle;
endmodule

// File: tb/tb_uart_rx_multi.sv
module tb_uart_rx_multi;
    localparam int unsigned OS = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BAUD_DIV = 2;
`ifdef UART_RX_MULTI_FIFO_EN
    localparam int unsigned MDEPTH = DEPTH;
`else
    localparam int unsigned MDEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_clock = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] data_bits = 2'b11;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       two_stop = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       clear_break = 1'b0;
    logic       overflow, break_det, rx_idle;

    uart_rx_multi_if bus ();

    uart_rx_multi #(
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .baud_clock     (baud_clock),
        .rx             (rx),
        .data_bits      (data_bits),
        .parity_en      (parity_en),
        .odd_n_even     (odd_n_even),
        .two_stop       (two_stop),
        .clear_overflow (clear_overflow),
        .clear_break    (clear_break),
        .rd             (bus.master),
        .overflow       (overflow),
        .break_det      (break_det),
        .rx_idle        (rx_idle)
    );

    initial forever #5 clk = ~clk;

    // baud_clock high for one clk out of every BAUD_DIV, changed on falling edges.
    initial begin
        int div_cnt;
        div_cnt = 0;
        forever begin
            @(negedge clk);
            div_cnt = (div_cnt + 1) % BAUD_DIV;
            baud_clock = (div_cnt == 0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: expected buffer contents {ferr, perr, data} and sticky flags.
    logic [9:0] exp_q[$];
    bit         m_ovf = 1'b0;
    bit         m_brk = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [9:0] h;
        check_eq({tag, ".valid"}, 32'(bus.rx_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check_eq({tag, ".data"}, 32'(bus.rx_data), 32'(h[7:0]));
            check_eq({tag, ".perr"}, 32'(bus.parity_err), 32'(h[8]));
            check_eq({tag, ".ferr"}, 32'(bus.framing_err), 32'(h[9]));
        end
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, ".brk"}, 32'(break_det), 32'(m_brk));
        check_eq({tag, ".idle"}, 32'(rx_idle), 32'd1);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Return on the falling edge right after a baud_clock sampling edge.
    task automatic align_baud();
        @(posedge clk);
        while (!baud_clock) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int ticks);
        rx = v;
        repeat (ticks * BAUD_DIV) @(negedge clk);
    endtask

    task automatic pop_entry(input string tag);
        bus.rx_read = 1'b1;
        @(negedge clk);
        bus.rx_read = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic pulse_clear_ovf();
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic pulse_clear_brk();
        clear_break = 1'b1;
        @(negedge clk);
        clear_break = 1'b0;
        m_brk = 1'b0;
    endtask

    // Send one frame, optionally pulsing rx_read in the commit cycle, then update the model.
    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit odd,
                              input bit ts, input bit bad_par, input bit s1_low,
                              input bit s2_low, input bit rd_at_commit);
        logic [7:0] mask, dm;
        logic       pbit;
        bit         brk;
        int         commit_k;
        logic [9:0] w;
        mask = 8'((1 << nb) - 1);
        dm   = d & mask;
        pbit = (^dm) ^ odd ^ bad_par;
        brk  = (dm == 8'h00) && (!pen || !pbit) && s1_low;
        // Bit index (start bit = 0) of the stop bit whose centre commits the word.
        commit_k = 1 + nb + int'(pen) + int'(ts);
        data_bits  = 2'(nb - 5);
        parity_en  = pen;
        odd_n_even = odd;
        two_stop   = ts;
        align_baud();
        fork
            begin
                drive_bit(1'b0, OS);
                for (int i = 0; i < nb; i++) drive_bit(dm[i], OS);
                if (pen) drive_bit(pbit, OS);
                drive_bit(!s1_low, OS);
                if (ts) drive_bit(!s2_low, OS);
                drive_bit(1'b1, 2 * OS);
            end
            begin
                if (rd_at_commit && !brk) begin
                    // Filter plus start detection take 2 ticks; centre sampling follows.
                    int n;
                    int k_ticks;
                    n = 0;
                    k_ticks = 2 + OS / 2 + OS * commit_k;
                    while (n < k_ticks) begin
                        @(posedge clk);
                        if (baud_clock) n++;
                    end
                    @(negedge clk);
                    @(posedge clk);
                    @(negedge clk);
                    bus.rx_read = 1'b1;
                    @(negedge clk);
                    bus.rx_read = 1'b0;
                end
            end
        join
        if (brk) begin
            m_brk = 1'b1;
        end else begin
            w = {s1_low | (ts & s2_low), pen & bad_par, dm};
            if (rd_at_commit && exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_q.size() < MDEPTH) exp_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    initial begin
        bit idle_min, saw_busy;
        bus.rx_read = 1'b0;
        wait_clks(5);
        check_eq("rst.data", 32'(bus.rx_data), 32'h0);
        check_eq("rst.valid", 32'(bus.rx_valid), 32'h0);
        check_eq("rst.perr", 32'(bus.parity_err), 32'h0);
        check_eq("rst.ferr", 32'(bus.framing_err), 32'h0);
        check_eq("rst.ovf", 32'(overflow), 32'h0);
        check_eq("rst.brk", 32'(break_det), 32'h0);
        check_eq("rst.idle", 32'(rx_idle), 32'h1);
        reset_n = 1'b1;
        wait_clks(40);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0, 0);
        check_eq("8n1.data_lit", 32'(bus.rx_data), 32'hA5);
        check_state("8n1");
        pop_entry("8n1.pop");

        // 7O1 0x41, good then bad parity
        send_frame(8'h41, 7, 1, 1, 0, 0, 0, 0, 0);
        check_eq("7o1.good_perr", 32'(bus.parity_err), 32'h0);
        check_state("7o1.good");
        pop_entry("7o1.good_pop");
        send_frame(8'h41, 7, 1, 1, 0, 1, 0, 0, 0);
        check_eq("7o1.bad_perr", 32'(bus.parity_err), 32'h1);
        check_state("7o1.bad");
        pop_entry("7o1.bad_pop");

        // 8N2 with second stop bit low
        send_frame(8'h3C, 8, 0, 0, 1, 0, 0, 1, 0);
        check_eq("8n2.ferr", 32'(bus.framing_err), 32'h1);
        check_state("8n2");
        pop_entry("8n2.pop");
        two_stop = 1'b0;

        // Glitch rejection: 1-tick pulse never leaves IDLE
        align_baud();
        rx = 1'b0;
        wait_clks(BAUD_DIV);
        rx = 1'b1;
        idle_min = 1'b1;
        repeat (40) begin
            @(negedge clk);
            idle_min &= rx_idle;
        end
        check_eq("glitch1.idle_held", 32'(idle_min), 32'h1);
        check_state("glitch1");

        // 6-tick pulse enters START then aborts
        align_baud();
        rx = 1'b0;
        saw_busy = 1'b0;
        repeat (6 * BAUD_DIV) begin
            @(negedge clk);
            saw_busy |= !rx_idle;
        end
        rx = 1'b1;
        repeat (2 * OS * BAUD_DIV) begin
            @(negedge clk);
            saw_busy |= !rx_idle;
        end
        check_eq("glitch6.started", 32'(saw_busy), 32'h1);
        check_state("glitch6");

        // Overflow without read
        for (int i = 1; i <= MDEPTH + 1; i++) send_frame(8'(i), 8, 0, 0, 0, 0, 0, 0, 0);
        check_eq("ovf.flag", 32'(overflow), 32'h1);
        check_state("ovf.full");
        for (int i = 1; i <= MDEPTH; i++) begin
            check_eq("ovf.pop_data", 32'(bus.rx_data), 32'(i));
            pop_entry("ovf.pop");
        end
        check_eq("ovf.empty", 32'(bus.rx_valid), 32'h0);
        pulse_clear_ovf();
        check_state("ovf.cleared");

        // Full buffer with rx_read on the commit cycle: no overflow
        for (int i = 1; i <= MDEPTH; i++) send_frame(8'(i), 8, 0, 0, 0, 0, 0, 0, 0);
        send_frame(8'(MDEPTH + 1), 8, 0, 0, 0, 0, 0, 0, 1);
        check_eq("ovf_rd.flag", 32'(overflow), 32'h0);
        check_state("ovf_rd");
        while (exp_q.size() != 0) pop_entry("ovf_rd.drain");

        // Break: line low for 20 bit times
        align_baud();
        drive_bit(1'b0, 20 * OS);
        check_eq("brk.flag", 32'(break_det), 32'h1);
        check_eq("brk.no_entry", 32'(bus.rx_valid), 32'h0);
        check_eq("brk.waiting", 32'(rx_idle), 32'h0);
        m_brk = 1'b1;
        drive_bit(1'b1, 2 * OS);
        check_state("brk.released");
        pulse_clear_brk();
        check_state("brk.cleared");

        // Randomized frames
        for (int n = 0; n < 30; n++) begin
            int  nb;
            bit  pen, odd, ts, bad, s1l, s2l, rac;
            logic [7:0] d;
            nb  = 5 + int'($urandom_range(3, 0));
            pen = 1'($urandom_range(1, 0));
            odd = 1'($urandom_range(1, 0));
            ts  = 1'($urandom_range(1, 0));
            d   = 8'($urandom);
            if ($urandom_range(7, 0) == 0) d = 8'h00;
            bad = pen && ($urandom_range(3, 0) == 0);
            s1l = ($urandom_range(5, 0) == 0);
            s2l = ts && ($urandom_range(3, 0) == 0);
            rac = (exp_q.size() == MDEPTH) && ($urandom_range(3, 0) == 0);
            send_frame(d, nb, pen, odd, ts, bad, s1l, s2l, rac);
            check_state("rnd.frame");
            if (m_brk) pulse_clear_brk();
            if ($urandom_range(1, 0) == 1 && exp_q.size() != 0) pop_entry("rnd.pop");
            if (m_ovf && $urandom_range(1, 0) == 1) begin
                pulse_clear_ovf();
                check_state("rnd.clr_ovf");
            end
        end
        while (exp_q.size() != 0) pop_entry("final.drain");
        check_state("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
